dma_chan_rx: RTL
================

DMA_CHAN_RX -- requirements
Module: dma_chan_rx

Interface
REQ-001 SHALL have parameter MEM_AW, default 13, meaning memory word-address width.
REQ-002 SHALL have parameter BUF_DEPTH, default 32, meaning number of device buffer words.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-004 SHALL have port rst_n, input, 1, the reset: asynchronous and active-low.
REQ-005 SHALL have port cfg_start, input, 1, a one-cycle arm pulse.
REQ-006 SHALL have port cfg_len, input, 6, words to move (0..32), sampled on cfg_start.
REQ-007 SHALL have port cfg_base, input, MEM_AW, memory destination base, sampled on cfg_start.
REQ-008 SHALL have port GPIO2, input, 1, device data-ready request.
REQ-009 SHALL have port Ack2, output, 1, grant to the device.
REQ-010 SHALL have port index, output, 9, device select: bit 8 is chip-select, bits 7:0 are the buffer address.
REQ-011 SHALL have port IOWrite2, output, 1, device direction: 0 = read, 1 = write.
REQ-012 SHALL have ports dev_rdata (input, 32, device read data) and dev_wdata (output, 32, device write data).
REQ-013 SHALL have ports mem_addr (output, MEM_AW), mem_wdata (output, 32), mem_we (output, 1) and mem_ready (input, 1, write accepted).
REQ-014 SHALL have ports busy (output, 1), done (output, 1, one-cycle pulse), short_xfer (output, 1) and xfer_cnt (output, 6).

Function
REQ-015 SHALL implement the states IDLE, ARMED, RD_ADDR, RD_CAP, MEM_WR, CLEAR, DONE.
REQ-016 IDLE: cfg_start latches len/base, clears xfer_cnt, goes to ARMED; cfg_start is ignored outside IDLE.
REQ-017 ARMED: when GPIO2=1, SHALL assert Ack2 and go to RD_ADDR; if len=0, SHALL go directly to DONE without asserting Ack2.
REQ-018 RD_ADDR: SHALL drive index={1'b1, xfer_cnt[7:0]} with IOWrite2=0 for one cycle.
REQ-019 RD_CAP: SHALL hold index and sample dev_rdata at the end of the cycle; device read latency is exactly 1 cycle after address.
REQ-020 MEM_WR: SHALL hold mem_we=1, mem_addr=base+xfer_cnt (wraps modulo 2^MEM_AW) and mem_wdata=captured word until mem_ready=1.
REQ-021 After mem_ready, xfer_cnt SHALL increment; if xfer_cnt==len or xfer_cnt==BUF_DEPTH, go to DONE; else if GPIO2=0, go to DONE with short_xfer=1; else go to RD_ADDR.
REQ-022 Ack2 SHALL stay 1 from leaving ARMED until entering DONE.
REQ-023 DONE: SHALL pulse done for one cycle, drop Ack2, then return to IDLE; short_xfer SHALL hold until the next cfg_start.
REQ-024 GPIO2 falling during RD_ADDR, RD_CAP or MEM_WR SHALL NOT abort the current word; it is checked only at the word boundary.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 index[8] SHALL be 0 and IOWrite2 SHALL be 0 in IDLE, ARMED and DONE; dev_wdata SHALL be 0 unless in CLEAR.

Reset
REQ-027 rst_n low SHALL force IDLE asynchronously, including mid-transfer, with no completing memory write.
REQ-028 On reset, all outputs SHALL be 0 and latched len/base/data SHALL be cleared.

Configuration
REQ-029 With DMA_CHAN_CLEAR_EN defined, the FSM SHALL insert CLEAR between MEM_WR and the next-word decision, driving one cycle of index={1,addr}, IOWrite2=1 and dev_wdata=0 to zero the drained word.
REQ-030 Without DMA_CHAN_CLEAR_EN, CLEAR SHALL be absent and IOWrite2 SHALL be constant 0.

Structure
REQ-031 Package dma_pkg SHALL hold the state enum, BUF_DEPTH_DEF=32, IDX_CS_BIT=8 and the IDX_W=9 constant.
REQ-032 The word/address counter SHALL be sub-module dma_xfer_cnt (load, increment, terminal-count flag); the FSM SHALL stay in dma_chan_rx.

Verification
REQ-033 Start with len=4 and base=0x100, GPIO2 high, device words 0..3 = A0..A3, mem_ready tied 1 -> memory 0x100..0x103 = A0..A3; done pulses once; xfer_cnt=4; short_xfer=0.
REQ-034 Start with len=0 -> done within 2 cycles; Ack2 never asserted; no mem_we.
REQ-035 len=8, GPIO2 dropped during word 2's MEM_WR -> words 0..2 written; short_xfer=1; xfer_cnt=3.
REQ-036 len=2, mem_ready held low for 5 cycles -> mem_we/mem_addr/mem_wdata stable throughout; no double write.
REQ-037 base=0x1FFF, len=3 -> writes land at 0x1FFF, 0x0000, 0x0001.
REQ-038 rst_n low mid-MEM_WR -> all outputs 0 immediately; after release, a new cfg_start runs a clean transfer; with DMA_CHAN_CLEAR_EN, device words read back 0.

Source files
------------

// File: rtl/dma_pkg.sv
// Shared types and constants for the dma_chan_rx receive channel.
// DMA_CHAN_CLEAR_EN adds the CLEAR state that zeroes each drained device word.
package dma_pkg;

  localparam int unsigned BUF_DEPTH_DEF = 32;
  localparam int unsigned IDX_W         = 9;
  localparam int unsigned IDX_CS_BIT    = 8;
  localparam int unsigned CNT_W         = 6;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    RD_ADDR = 3'd2,
    RD_CAP  = 3'd3,
    MEM_WR  = 3'd4,
`ifdef DMA_CHAN_CLEAR_EN
    CLEAR   = 3'd5,
`endif
    DONE    = 3'd6
  } dma_state_e;

  // Device select word: chip-select set, buffer address in the low bits.
  function automatic logic [IDX_W-1:0] dev_sel(input logic [CNT_W-1:0] addr);
    logic [IDX_W-1:0] sel;
    sel             = '0;
    sel[IDX_CS_BIT] = 1'b1;
    sel[CNT_W-1:0]  = addr;
    return sel;
  endfunction

endpackage

// File: rtl/dma_xfer_cnt.sv
// Word/address counter for dma_chan_rx: clear, increment, and a flag that
// the incremented count reaches the programmed length or the buffer depth.
module dma_xfer_cnt
  import dma_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic [CNT_W-1:0] len,
  output logic [CNT_W-1:0] cnt,
  output logic [CNT_W-1:0] cnt_nxt,
  output logic             last
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  always_comb begin
    cnt_inc = {1'b0, cnt_q} + (CNT_W+1)'(1);
    cnt_d   = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
    last = (cnt_inc == {1'b0, len}) || (cnt_inc == (CNT_W+1)'(BUF_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign cnt_nxt = cnt_d;

endmodule

// File: rtl/dma_chan_rx.sv
// Device-to-memory receive DMA channel: drains device buffer words into memory.
// Define DMA_CHAN_CLEAR_EN to zero each device word after it has been written.
module dma_chan_rx
  import dma_pkg::*;
#(
  parameter int unsigned MEM_AW    = 13,
  parameter int unsigned BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [CNT_W-1:0]  cfg_len,
  input  logic [MEM_AW-1:0] cfg_base,
  input  logic              GPIO2,
  output logic              Ack2,
  output logic [IDX_W-1:0]  index,
  output logic              IOWrite2,
  input  logic [31:0]       dev_rdata,
  output logic [31:0]       dev_wdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic              busy,
  output logic              done,
  output logic              short_xfer,
  output logic [CNT_W-1:0]  xfer_cnt
);

  dma_state_e        state_q, state_d, after_word;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic              short_q, short_d, after_short;
  logic              ack_q, ack_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              mem_we_q, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cnt_clr, cnt_inc, cnt_last;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
`ifdef DMA_CHAN_CLEAR_EN
  logic              iow_q, iow_d;
`endif

  dma_xfer_cnt #(
    .BUF_DEPTH (BUF_DEPTH)
  ) u_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (cnt_clr),
    .inc     (cnt_inc),
    .len     (len_q),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .last    (cnt_last)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    base_d  = base_q;
    data_d  = data_q;
    short_d = short_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    // Word-boundary decision; GPIO2 only matters once a word has fully drained.
    after_short = !cnt_last && !GPIO2;
    after_word  = (cnt_last || !GPIO2) ? DONE : RD_ADDR;

    case (state_q)
      IDLE: begin
        if (cfg_start) begin
          len_d   = cfg_len;
          base_d  = cfg_base;
          short_d = 1'b0;
          cnt_clr = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (len_q == '0) begin
          state_d = DONE;
        end else if (GPIO2) begin
          state_d = RD_ADDR;
        end
      end
      RD_ADDR: state_d = RD_CAP;
      RD_CAP: begin
        data_d  = dev_rdata;
        state_d = MEM_WR;
      end
      MEM_WR: begin
        if (mem_ready) begin
`ifdef DMA_CHAN_CLEAR_EN
          state_d = CLEAR;
`else
          cnt_inc = 1'b1;
          short_d = after_short;
          state_d = after_word;
`endif
        end
      end
`ifdef DMA_CHAN_CLEAR_EN
      CLEAR: begin
        cnt_inc = 1'b1;
        short_d = after_short;
        state_d = after_word;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
    ack_d       = !(state_d inside {IDLE, ARMED, DONE});
    idx_d       = '0;
    mem_we_d    = (state_d == MEM_WR);
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (state_d inside {RD_ADDR, RD_CAP}) begin
      idx_d = dev_sel(cnt_nxt);
    end
`ifdef DMA_CHAN_CLEAR_EN
    iow_d = (state_d == CLEAR);
    if (state_d == CLEAR) begin
      idx_d = dev_sel(cnt_nxt);
    end
`endif
    if (mem_we_d) begin
      mem_addr_d  = base_q + MEM_AW'(cnt_nxt);
      mem_wdata_d = data_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      len_q       <= '0;
      base_q      <= '0;
      data_q      <= '0;
      short_q     <= 1'b0;
      ack_q       <= 1'b0;
      idx_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef DMA_CHAN_CLEAR_EN
      iow_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      base_q      <= base_d;
      data_q      <= data_d;
      short_q     <= short_d;
      ack_q       <= ack_d;
      idx_q       <= idx_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef DMA_CHAN_CLEAR_EN
      iow_q       <= iow_d;
`endif
    end
  end

  assign Ack2       = ack_q;
  assign index      = idx_q;
  assign dev_wdata  = '0;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign short_xfer = short_q;
  assign xfer_cnt   = cnt;
`ifdef DMA_CHAN_CLEAR_EN
  assign IOWrite2   = iow_q;
`else
  assign IOWrite2   = 1'b0;
`endif

endmodule
